// File: rtl/game_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the invader game controller.
//   game_state_t      : IDLE=0, PLAY=1, WIN=2, LOSE=3
//   ROW_POINTS_*      : BCD points awarded per row (row 0 = 30, row 1 = 20,
//                       any lower row = 10)
//   BCD_SAT           : saturation value of the four-digit BCD score
//   SPEED_TH_*        : alive-count thresholds for the formation speed index
//   row_points()      : row index -> BCD points
//   speed_from_count(): alive count -> speed index 0..4
// ----------------------------------------------------------------------------
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        WIN  = 2'd2,
        LOSE = 2'd3
    } game_state_t;

    localparam logic [7:0]  ROW_POINTS_0 = 8'h30;
    localparam logic [7:0]  ROW_POINTS_1 = 8'h20;
    localparam logic [7:0]  ROW_POINTS_N = 8'h10;

    localparam logic [15:0] BCD_SAT = 16'h9999;

    localparam int unsigned SPEED_TH_0 = 24;
    localparam int unsigned SPEED_TH_1 = 16;
    localparam int unsigned SPEED_TH_2 = 8;
    localparam int unsigned SPEED_TH_3 = 2;

    function automatic logic [7:0] row_points(input logic [1:0] row);
        case (row)
            2'd0:    return ROW_POINTS_0;
            2'd1:    return ROW_POINTS_1;
            default: return ROW_POINTS_N;
        endcase
    endfunction

    // Fewer survivors -> faster formation; one and zero share the top speed.
    function automatic logic [2:0] speed_from_count(input int unsigned cnt);
        if (cnt >= SPEED_TH_0)      return 3'd0;
        else if (cnt >= SPEED_TH_1) return 3'd1;
        else if (cnt >= SPEED_TH_2) return 3'd2;
        else if (cnt >= SPEED_TH_3) return 3'd3;
        else                        return 3'd4;
    endfunction

endpackage

// File: rtl/bcd_add4.sv
// ----------------------------------------------------------------------------
// bcd_add4
// Combinational four-digit BCD adder: 16-bit BCD plus 8-bit BCD, saturating
// at 0x9999 when the top digit carries out. Inputs are assumed to be valid
// BCD.
// Ports:
//   a   [15:0] in  : four packed BCD digits
//   b   [7:0]  in  : two packed BCD digits
//   sum [15:0] out : saturated BCD sum
// ----------------------------------------------------------------------------
module bcd_add4
    import game_pkg::*;
(
    input  logic [15:0] a,
    input  logic [7:0]  b,
    output logic [15:0] sum
);

    function automatic logic [15:0] sat_bcd(input logic [15:0] raw, input logic ovf);
        return ovf ? BCD_SAT : raw;
    endfunction

    logic [15:0] b_ext;
    logic [15:0] raw;
    logic        carry;
    logic [4:0]  digit;

    assign b_ext = {8'h00, b};

    always_comb begin
        raw   = '0;
        carry = 1'b0;
        digit = '0;
        for (int i = 0; i < 4; i++) begin
            digit = {1'b0, a[4*i +: 4]} + {1'b0, b_ext[4*i +: 4]} + {4'b0000, carry};
            if (digit > 5'd9) begin
                raw[4*i +: 4] = 4'(digit - 5'd10);
                carry         = 1'b1;
            end else begin
                raw[4*i +: 4] = digit[3:0];
                carry         = 1'b0;
            end
        end
        sum = sat_bcd(raw, carry);
    end

endmodule

// File: rtl/game_state_ctl.sv
// ----------------------------------------------------------------------------
// game_state_ctl
// Top-level game controller: IDLE/PLAY/WIN/LOSE sequencing, per-invader alive
// bitmap, BCD score and (optionally) formation speed index.
// Parameters:
//   NUM_INVADERS : invaders per row
//   NUM_ROWS     : invader rows
//   HOLD_FRAMES  : frame_tick pulses spent in WIN/LOSE before returning to IDLE
// Ports:
//   clk             in  : pixel clock
//   rst             in  : synchronous reset, active low
//   frame_tick      in  : one-cycle pulse per frame
//   start           in  : shoot-button level; only its rising edge acts
//   hit_valid       in  : one-cycle bullet-hit pulse
//   hit_row   [1:0] in  : hit row, 0 = top
//   hit_col   [3:0] in  : hit column
//   invaders_landed in  : formation reached the player row (level)
//   alive     [R*N-1:0] out : alive bitmap, bit r*NUM_INVADERS+c = invader (r,c)
//   game_state[1:0] out : IDLE=0, PLAY=1, WIN=2, LOSE=3
//   score    [15:0] out : four packed BCD digits
//   speed_level[2:0] out: formation speed index
// Configuration:
//   GAME_SPEEDUP_EN : when defined, speed_level is registered from the alive
//                     popcount; otherwise it is tied to 0.
// ----------------------------------------------------------------------------
module game_state_ctl
    import game_pkg::*;
#(
    parameter int NUM_INVADERS = 10,
    parameter int NUM_ROWS     = 3,
    parameter int HOLD_FRAMES  = 120
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_tick,
    input  logic                           start,
    input  logic                           hit_valid,
    input  logic [1:0]                     hit_row,
    input  logic [3:0]                     hit_col,
    input  logic                           invaders_landed,
    output logic [NUM_ROWS*NUM_INVADERS-1:0] alive,
    output logic [1:0]                     game_state,
    output logic [15:0]                    score,
    output logic [2:0]                     speed_level
);

    localparam int N_TOT  = NUM_ROWS * NUM_INVADERS;
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);
    localparam logic [N_TOT-1:0]  ALL_ALIVE = '1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    game_state_t       state_q, state_d;
    logic [N_TOT-1:0]  alive_q, alive_d;
    logic [15:0]       score_q, score_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              start_p0;

    logic              start_edge;
    logic [31:0]       row_ext, col_ext, hit_idx;
    logic              in_range;
    logic [N_TOT-1:0]  hit_mask;
    logic              hit_ok;
    logic              kill_last;
    logic [7:0]        hit_points;
    logic [15:0]       score_sum;

    assign start_edge = start & ~start_p0;

    // Range is checked before the mask is used, so an out-of-range index
    // that shifts the one-hot bit off the end can never be accepted.
    assign row_ext  = 32'(hit_row);
    assign col_ext  = 32'(hit_col);
    assign hit_idx  = row_ext * NUM_INVADERS + col_ext;
    assign in_range = (row_ext < NUM_ROWS) && (col_ext < NUM_INVADERS);
    assign hit_mask = {{(N_TOT-1){1'b0}}, 1'b1} << hit_idx;
    assign hit_ok   = hit_valid && (state_q == PLAY) && in_range && |(alive_q & hit_mask);
    assign kill_last = hit_ok && ((alive_q & ~hit_mask) == '0);

    assign hit_points = row_points(hit_row);

    bcd_add4 u_bcd_add4 (
        .a   (score_q),
        .b   (hit_points),
        .sum (score_sum)
    );

    always_comb begin
        state_d = state_q;
        alive_d = alive_q;
        score_d = score_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                hold_d = '0;
                if (start_edge) begin
                    state_d = PLAY;
                    alive_d = ALL_ALIVE;
                    score_d = '0;
                end
            end
            PLAY: begin
                hold_d = '0;
                if (hit_ok) begin
                    alive_d = alive_q & ~hit_mask;
                    score_d = score_sum;
                end
                // An empty field wins over landing; a last-invader kill in the
                // same cycle as landing suppresses LOSE so WIN follows next.
                if (alive_q == '0) begin
                    state_d = WIN;
                end else if (invaders_landed && !kill_last) begin
                    state_d = LOSE;
                end
            end
            WIN, LOSE: begin
                if (frame_tick) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = IDLE;
                        alive_d = ALL_ALIVE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            alive_q  <= ALL_ALIVE;
            score_q  <= '0;
            hold_q   <= '0;
            start_p0 <= 1'b0;
        end else begin
            state_q  <= state_d;
            alive_q  <= alive_d;
            score_q  <= score_d;
            hold_q   <= hold_d;
            start_p0 <= start;
        end
    end

    assign alive      = alive_q;
    assign game_state = state_q;
    assign score      = score_q;

`ifdef GAME_SPEEDUP_EN
    localparam int CNT_W = $clog2(N_TOT + 1);

    logic [CNT_W-1:0] pop_cnt;
    logic [2:0]       speed_p1;

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < N_TOT; i++) begin
            pop_cnt = pop_cnt + CNT_W'(alive_q[i]);
        end
    end

    // Speed stage: follows the registered bitmap one cycle later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            speed_p1 <= 3'd0;
        end else begin
            speed_p1 <= speed_from_count(32'(pop_cnt));
        end
    end

    assign speed_level = speed_p1;
`else
    assign speed_level = 3'd0;
`endif

endmodule

// File: tb/tb_game_state_ctl.sv
module tb_game_state_ctl;

    localparam logic [29:0] ALL = '1;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_tick;
    logic        start;
    logic        hit_valid;
    logic [1:0]  hit_row;
    logic [3:0]  hit_col;
    logic        invaders_landed;
    logic [29:0] alive;
    logic [1:0]  game_state;
    logic [15:0] score;
    logic [2:0]  speed_level;

    logic [15:0] add_a;
    logic [7:0]  add_b;
    logic [15:0] add_sum;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [29:0] exp_alive;
    int          exp_pts;
    logic [2:0]  exp_speed;

    always #5 clk = ~clk;

    game_state_ctl dut (
        .clk             (clk),
        .rst             (rst),
        .frame_tick      (frame_tick),
        .start           (start),
        .hit_valid       (hit_valid),
        .hit_row         (hit_row),
        .hit_col         (hit_col),
        .invaders_landed (invaders_landed),
        .alive           (alive),
        .game_state      (game_state),
        .score           (score),
        .speed_level     (speed_level)
    );

    bcd_add4 u_add (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hit(input int r, input int c, input logic landed);
        hit_row         = 2'(r);
        hit_col         = 4'(c);
        hit_valid       = 1'b1;
        invaders_landed = landed;
        tick();
        hit_valid       = 1'b0;
        invaders_landed = 1'b0;
    endtask

    task automatic start_game();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            tick();
        end
    endtask

    initial begin
        rst = 1'b0; frame_tick = 1'b0; start = 1'b0; hit_valid = 1'b0;
        hit_row = '0; hit_col = '0; invaders_landed = 1'b0;
        add_a = '0; add_b = '0;
        repeat (2) tick();
        check("rst_state", game_state, 0);
        check("rst_alive", alive, ALL);
        check("rst_score", score, 0);
        check("rst_speed", speed_level, 0);
        rst = 1'b1;
        tick();
        check("idle_hold", game_state, 0);

        // start edge -> PLAY next cycle
        start = 1'b1;
        tick();
        check("start_state", game_state, 1);
        check("start_alive", alive, ALL);
        check("start_score", score, 0);
        tick();
        start = 1'b0;
        tick();

        exp_alive = ALL & ~(30'd1 << 3);
        hit(0, 3, 1'b0);
        check("hit03_alive", alive, exp_alive);
        check("hit03_score", score, 16'h0030);
        hit(0, 3, 1'b0);
        check("rehit_score", score, 16'h0030);
        check("rehit_alive", alive, exp_alive);
        hit(0, 12, 1'b0);
        check("col12_alive", alive, exp_alive);
        check("col12_score", score, 16'h0030);
        hit(3, 0, 1'b0);
        check("row3_alive", alive, exp_alive);
        check("row3_score", score, 16'h0030);
        check("play_state", game_state, 1);

        exp_alive = exp_alive & ~(30'd1 << 10);
        hit(1, 0, 1'b0);
        check("row1_score", score, 16'h0050);
        exp_alive = exp_alive & ~(30'd1 << 20);
        hit(2, 0, 1'b0);
        check("row2_score", score, 16'h0060);
        check("row2_alive", alive, exp_alive);

        // clear the rest; the final kill coincides with landing
        exp_pts = 60;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 10; c++) begin
                if (exp_alive[r*10 + c]) begin
                    hit(r, c, (r == 2 && c == 9));
                    exp_alive[r*10 + c] = 1'b0;
                    exp_pts += (r == 0) ? 30 : (r == 1) ? 20 : 10;
                end
            end
        end
        check("clear_alive", alive, 0);
        check("clear_score", score, to_bcd(exp_pts));
        tick();
        check("win_state", game_state, 2);

        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("win_start_ign", game_state, 2);
        frames(119);
        check("win_119", game_state, 2);
        frames(1);
        check("win_exit_state", game_state, 0);
        check("win_exit_alive", alive, ALL);
        check("win_exit_score", score, 16'h0600);

        // saturation and carry through the BCD adder
        add_a = 16'h9990; add_b = 8'h20; #1;
        check("bcd_sat", add_sum, 16'h9999);
        add_a = 16'h0990; add_b = 8'h30; #1;
        check("bcd_carry", add_sum, 16'h1020);
        add_a = 16'h0599; add_b = 8'h01; #1;
        check("bcd_ripple", add_sum, 16'h0600);
        add_a = 16'h9999; add_b = 8'h00; #1;
        check("bcd_max", add_sum, 16'h9999);

        // landing -> LOSE, hits ignored outside PLAY
        start_game();
        check("g2_score", score, 0);
        check("g2_state", game_state, 1);
        invaders_landed = 1'b1;
        tick();
        invaders_landed = 1'b0;
        check("lose_state", game_state, 3);
        hit(0, 0, 1'b0);
        check("lose_hit_alive", alive, ALL);
        check("lose_hit_score", score, 0);
        frames(120);
        check("lose_exit", game_state, 0);

        // speed index from survivors: 23 kills leave 7
        start_game();
        for (int i = 0; i < 23; i++) hit(i / 10, i % 10, 1'b0);
        tick();
        check("sp_alive", alive, ALL & ~((30'd1 << 23) - 30'd1));
`ifdef GAME_SPEEDUP_EN
        exp_speed = 3'd3;
`else
        exp_speed = 3'd0;
`endif
        check("sp_level", speed_level, exp_speed);

        // reset wins over a pending hit
        hit_row = 2'd2; hit_col = 4'd5; hit_valid = 1'b1; rst = 1'b0;
        tick();
        hit_valid = 1'b0; rst = 1'b1;
        check("mrst_state", game_state, 0);
        check("mrst_alive", alive, ALL);
        check("mrst_score", score, 0);
        check("mrst_speed", speed_level, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
